serial_deserializer_8bit: RTL and testbench
===========================================

Name: serial_deserializer_8bit

Overview:
Receive end of the 8-bit serial link: collects one bit per accepted beat and steers it into the lane chosen by a 3-bit counter, the sequential dual of the 8-to-1 select. Presents the assembled byte through a one-entry output register with a valid/ready handshake. Sits between a bit-serial source and the 8-bit datapath (XOR/OR/AND stages).

Parameters:
MSB_FIRST, 0, 0: first accepted bit lands in out[0], the LSB. 1: first bit lands in out[7].

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
num  input  1  serial data bit
num_valid  input  1  num is valid this cycle
num_ready  output  1  block accepts num this cycle
flush  input  1  synchronous discard of a partial byte
out  output  8  assembled byte
out_valid  output  1  out holds an unconsumed byte
out_ready  input  1  consumer takes out this cycle
op  output  3  current lane counter, exposed for debug

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: out=8'h00, out_valid=0, op=3'd0, assembly register=8'h00.
  - num_ready equals 1 combinationally once rst is released.
- Accept rule: a bit is accepted when num_valid && num_ready.
- Lane steering:
  - An accepted bit writes lane op when MSB_FIRST=0, or lane 7-op when MSB_FIRST=1.
  - The write goes into the assembly register. Other lanes hold.
  - op then increments modulo 8.
- Completion: a bit accepted at op=7 completes the byte.
  - Next cycle: out equals the assembly value including that bit, out_valid=1, op=0.
  - Latency is 1 cycle from the last accepted bit to out_valid.
- Output hold: out and out_valid stay stable until out_valid && out_ready. After that out_valid=0 next cycle and out keeps its last value.
- Backpressure:
  - num_ready = !(op==7 && out_valid && !out_ready).
  - Bits 0..6 of the next byte are still accepted while the previous byte waits.
- Simultaneous drain and complete: out_valid && out_ready && completing accept in the same cycle loads the new byte. out_valid stays 1 with no bubble.
- FSM, 2 states:
  - ASSEMBLE: op counting, out_valid=0. Moves to HOLD on completion.
  - HOLD: out_valid=1. Goes back to ASSEMBLE on drain with no completion in the same cycle. Stays in HOLD on drain with a simultaneous completion.
- Flush:
  - Sets op=0 next cycle and clears the assembly register.
  - Any bit offered in the flush cycle is dropped.
  - Does not affect out or out_valid.
  - num_ready stays as defined above.
- Reset mid-byte: all state returns to reset values immediately. The partial byte and any pending output are lost.
- The assembly register is not cleared on completion; every lane is rewritten before the next completion.

Optional Feature:
Macro SERIAL_DESER_PARITY_EN.
- Defined:
  - Frames are 9 bits: 8 data bits then 1 even-parity bit. op widens to 4 bits and counts 0..8.
  - Completion happens on the parity bit at op=8. The op==7 term in the backpressure rule becomes op==8.
  - Adds output parity_err (1 bit). It updates together with out and is 1 when XOR(out, parity bit) != 0. Reset value is 0.
- Undefined: 8-bit frames, no parity_err port, behaviour exactly as above.

Decomposition:
- Shared package serial_pkg:
  - BYTE_W=8, CNT_W=3, CNT_W_PAR=4.
  - State typedef {ASSEMBLE, HOLD}.
  - Function for the lane index under MSB_FIRST.
- One sub-module, lane_decode_3to8: 3-bit select plus enable to an 8-bit one-hot write strobe (the 1-to-8 demux). The top instantiates it to drive the per-lane write enables.

Test Plan:
- Reset, MSB_FIRST=0: send bits 1,0,1,1,0,0,1,0 with out_ready=1.
  - Expect out=8'h4D and out_valid pulsed for 1 cycle, 1 cycle after the 8th bit; op back to 0.
- MSB_FIRST=1: send the same bit sequence.
  - Expect out=8'hB2.
- Backpressure with out_ready=0: stream 16 bits continuously.
  - First byte holds stable. num_ready=0 at op=7 of the second byte.
  - Raise out_ready: first byte drains, second byte appears next cycle with out_valid never dropping.
- Flush after 3 bits, then send 8'hA5 serially.
  - Expect out=8'hA5; the earlier partial bits are absent.
- Assert rst after 5 bits while out_valid=1.
  - Expect out_valid=0, out=0, op=0 immediately; the next full byte assembles correctly.
- SERIAL_DESER_PARITY_EN defined: send 8'h03 with parity 0, then 8'h03 with parity 1.
  - Expect parity_err=0, then parity_err=1; out=8'h03 both times.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial receive path.
// Build with SERIAL_DESER_PARITY_EN defined for 9-bit frames that end in an even-parity bit.
package serial_pkg;

  localparam int BYTE_W    = 8;
  localparam int CNT_W     = 3;
  localparam int CNT_W_PAR = 4;

`ifdef SERIAL_DESER_PARITY_EN
  localparam int OP_W    = CNT_W_PAR;
  localparam int LAST_OP = 8;
`else
  localparam int OP_W    = CNT_W;
  localparam int LAST_OP = 7;
`endif

  typedef enum logic {
    ASSEMBLE = 1'b0,
    HOLD     = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] lane_idx(input logic [CNT_W-1:0] cnt, input bit msb_first);
    return msb_first ? (3'd7 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/lane_decode_3to8.sv
// 1-to-8 demux: turns a lane select plus enable into a one-hot write strobe.
// Latency: combinational.
// Backpressure: none, pure decode.
module lane_decode_3to8
  import serial_pkg::*;
(
  input  logic [CNT_W-1:0]  sel,
  input  logic              en,
  output logic [BYTE_W-1:0] strobe
);

  always_comb begin
    strobe = '0;
    if (en) strobe[sel] = 1'b1;
  end

endmodule

// File: rtl/serial_deserializer_8bit.sv
// Bit-serial to byte deserializer with a one-entry valid/ready output register.
// Latency: out_valid rises 1 cycle after the last accepted bit of a frame.
// Backpressure: stalls only the frame-final bit while an undrained byte is held.
// Optional SERIAL_DESER_PARITY_EN: 9-bit frames with trailing even parity and parity_err.
module serial_deserializer_8bit
  import serial_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              num,
  input  logic              num_valid,
  output logic              num_ready,
  input  logic              flush,
  output logic [BYTE_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef SERIAL_DESER_PARITY_EN
  output logic              parity_err,
`endif
  output logic [OP_W-1:0]   op
);

  state_t            state_q, state_d;
  logic              take, complete, lane_en;
  logic [CNT_W-1:0]  lane;
  logic [BYTE_W-1:0] strobe, asm_q, asm_d;

  // Only the frame-final bit needs somewhere to go, so only it waits on the consumer.
  assign num_ready = !((op == OP_W'(LAST_OP)) && out_valid && !out_ready);
  assign take      = num_valid && num_ready && !flush;
  assign complete  = take && (op == OP_W'(LAST_OP));

`ifdef SERIAL_DESER_PARITY_EN
  assign lane_en = take && (op != OP_W'(LAST_OP));
`else
  assign lane_en = take;
`endif

  assign lane = lane_idx(op[CNT_W-1:0], MSB_FIRST);

  lane_decode_3to8 u_lane_decode (
    .sel    (lane),
    .en     (lane_en),
    .strobe (strobe)
  );

  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < BYTE_W; i++) begin
      if (strobe[i]) asm_d[i] = num;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ASSEMBLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ASSEMBLE: if (complete) state_d = HOLD;
      HOLD:     if (out_ready && !complete) state_d = ASSEMBLE;
      default:  state_d = ASSEMBLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op    <= '0;
      asm_q <= '0;
      out   <= '0;
    end else begin
      if (flush) begin
        op    <= '0;
        asm_q <= '0;
      end else if (take) begin
        asm_q <= asm_d;
        op    <= complete ? '0 : op + 1'b1;
      end
      if (complete) out <= asm_d;
    end
  end

`ifdef SERIAL_DESER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           parity_err <= 1'b0;
    else if (complete) parity_err <= (^asm_q) ^ num;
  end
`endif

endmodule

// File: tb/tb_serial_deserializer_8bit.sv
// Bench for serial_deserializer_8bit: LSB-first and MSB-first instances share stimulus.
// Expected outputs come from a queue-based frame model.
module tb_serial_deserializer_8bit;

`ifdef SERIAL_DESER_PARITY_EN
  localparam int FRAME = 9;
  localparam int OPW   = 4;
  localparam int VW    = 2 + 2 + 16 + 2 * OPW + 2;
`else
  localparam int FRAME = 8;
  localparam int OPW   = 3;
  localparam int VW    = 2 + 2 + 16 + 2 * OPW;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           num = 1'b0, num_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic           num_ready0, num_ready1, out_valid0, out_valid1;
  logic [7:0]     out0, out1;
  logic [OPW-1:0] op0, op1;
`ifdef SERIAL_DESER_PARITY_EN
  logic           parity_err0, parity_err1;
`endif

  always #5 clk = ~clk;

  serial_deserializer_8bit #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .num(num), .num_valid(num_valid), .num_ready(num_ready0),
    .flush(flush), .out(out0), .out_valid(out_valid0), .out_ready(out_ready),
`ifdef SERIAL_DESER_PARITY_EN
    .parity_err(parity_err0),
`endif
    .op(op0)
  );

  serial_deserializer_8bit #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .num(num), .num_valid(num_valid), .num_ready(num_ready1),
    .flush(flush), .out(out1), .out_valid(out_valid1), .out_ready(out_ready),
`ifdef SERIAL_DESER_PARITY_EN
    .parity_err(parity_err1),
`endif
    .op(op1)
  );

  int vectors = 0;
  int miscompares = 0;

  bit         m_bits[$];
  bit         m_have;
  logic [7:0] m_out0, m_out1;
  bit         m_perr;
  logic [1:0] seen_rdy;
  bit         exp_rdy;

  function automatic void model_reset();
    m_bits.delete();
    m_have = 1'b0;
    m_out0 = 8'h00;
    m_out1 = 8'h00;
    m_perr = 1'b0;
  endfunction

  function automatic logic [VW-1:0] obs_vec();
`ifdef SERIAL_DESER_PARITY_EN
    return {seen_rdy, out_valid0, out_valid1, out0, out1, op0, op1, parity_err0, parity_err1};
`else
    return {seen_rdy, out_valid0, out_valid1, out0, out1, op0, op1};
`endif
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [OPW-1:0] cnt;
    cnt = OPW'(m_bits.size());
`ifdef SERIAL_DESER_PARITY_EN
    return {exp_rdy, exp_rdy, m_have, m_have, m_out0, m_out1, cnt, cnt, m_perr, m_perr};
`else
    return {exp_rdy, exp_rdy, m_have, m_have, m_out0, m_out1, cnt, cnt};
`endif
  endfunction

  // Drives one beat, samples num_ready before the edge, advances the model across it.
  task automatic drive_cycle(input bit v, input bit b, input bit r, input bit f);
    bit done, drain;
    num_valid = v; num = b; out_ready = r; flush = f;
    #1;
    seen_rdy = {num_ready0, num_ready1};
    exp_rdy  = !((m_bits.size() == FRAME - 1) && m_have && !r);
    @(posedge clk);
    done  = 1'b0;
    drain = m_have && r;
    if (!f && v && exp_rdy) begin
      m_bits.push_back(b);
      if (m_bits.size() == FRAME) begin
        for (int i = 0; i < 8; i++) begin
          m_out0[i]     = m_bits[i];
          m_out1[7 - i] = m_bits[i];
        end
        m_perr = 1'b0;
        for (int i = 0; i < FRAME; i++) m_perr = m_perr ^ m_bits[i];
        m_bits.delete();
        done = 1'b1;
      end
    end
    if (f) m_bits.delete();
    if (done) m_have = 1'b1;
    else if (drain) m_have = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    #3;
    vectors++;
    if ({out_valid0, out_valid1, out0, out1, op0, op1} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b%b out=%h/%h op=%0d/%0d want all zero",
               out_valid0, out_valid1, out0, out1, op0, op1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({num_ready0, num_ready1} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 11", {num_ready0, num_ready1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lsb_msb();
    bit seq[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < FRAME; i++) begin
      drive_cycle(1'b1, (i < 8) ? seq[i] : 1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL lsb_msb beat %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if ({out_valid0, out0, out1, op0} !== {1'b1, 8'h4D, 8'hB2, {OPW{1'b0}}}) begin
      miscompares++;
      $display("FAIL lsb_msb_byte: got v=%b out0=%h out1=%h op=%0d want v=1 4d b2 op=0",
               out_valid0, out0, out1, op0);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({out_valid0, out_valid1, out0} !== {2'b00, 8'h4D}) begin
      miscompares++;
      $display("FAIL lsb_msb_pulse: got v=%b%b out=%h want v=00 out=4d",
               out_valid0, out_valid1, out0);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 2 * FRAME; i++) begin
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL backpressure beat %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (seen_rdy !== 2'b00) begin
      miscompares++;
      $display("FAIL backpressure_stall: num_ready got %b want 00", seen_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(i == 0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL backpressure_drain beat %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        vectors++;
        if ({out_valid0, out_valid1} !== 2'b11) begin
          miscompares++;
          $display("FAIL backpressure_nobubble: out_valid got %b want 11", {out_valid0, out_valid1});
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [7:0] pat;
    pat = 8'hA5;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL flush_cycle: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < FRAME; i++) begin
      drive_cycle(1'b1, (i < 8) ? pat[i] : 1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL flush_frame beat %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if ({out_valid0, out0, out1} !== {1'b1, 8'hA5, 8'hA5}) begin
      miscompares++;
      $display("FAIL flush_byte: got v=%b out0=%h out1=%h want v=1 a5 a5", out_valid0, out0, out1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < FRAME + 5; i++) begin
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_fill beat %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    num_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid0, out_valid1, out0, out1, op0, op1} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: got v=%b%b out=%h/%h op=%0d/%0d want all zero",
               out_valid0, out_valid1, out0, out1, op0, op1);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < FRAME + 1; i++) begin
      drive_cycle(i < FRAME, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_refill beat %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

`ifdef SERIAL_DESER_PARITY_EN
  task automatic test_parity();
    logic [7:0] pat;
    pat = 8'h03;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < FRAME; i++) begin
        drive_cycle(1'b1, (i < 8) ? pat[i] : 1'(k), 1'b1, 1'b0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL parity frame %0d beat %0d: got %h want %h", k, i, obs_vec(), exp_vec());
        end
      end
      vectors++;
      if ({out0, parity_err0, parity_err1} !== {8'h03, 1'(k), 1'(k)}) begin
        miscompares++;
        $display("FAIL parity_err frame %0d: got out=%h err=%b%b want out=03 err=%0d%0d",
                 k, out0, parity_err0, parity_err1, k, k);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random beat %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_msb();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef SERIAL_DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
